// File: rtl/qmult_seq_pkg.sv
// -----------------------------------------------------------------------------
// qmult_seq_pkg
// Shared sign-magnitude definitions for the multiplier and the downstream
// sign-magnitude adder: word geometry, maximum magnitude, the sequencer state
// encoding and the canonical packing helper that never produces negative zero.
// No ports (package).
// -----------------------------------------------------------------------------
package qmult_seq_pkg;

    localparam int SM_N    = 16;
    localparam int SM_SIGN = SM_N - 1;
    localparam logic [SM_N-2:0] SM_MAG_MAX = {(SM_N-1){1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sm_state_e;

    // Pack sign and magnitude; a zero magnitude always carries a positive sign.
    function automatic logic [SM_N-1:0] to_sm(input logic sign, input logic [SM_N-2:0] mag);
        logic [SM_N-1:0] word;
        word[SM_SIGN]  = sign & (|mag);
        word[SM_N-2:0] = mag;
        return word;
    endfunction

endpackage

// File: rtl/qmult_seq.sv
// -----------------------------------------------------------------------------
// qmult_seq
// Sequential shift-add multiplier for sign-magnitude fixed-point words
// (bit N-1 sign, N-1 magnitude bits, Q fractional). One magnitude bit of the
// multiplier is consumed per clock; the product is truncated to Q fractional
// bits and saturated to the maximum magnitude on overflow.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   a/b valid
//   in_ready   out  block can accept an operand pair (registered)
//   a, b       in   N-bit sign-magnitude operands
//   out_valid  out  c/ovf valid (registered)
//   out_ready  in   consumer accepts c
//   c          out  N-bit sign-magnitude product (registered)
//   ovf        out  magnitude saturated (registered)
// Timing: accept edge is edge 0, CALC runs N-1 add cycles, the result
// registers load on the CALC->DONE edge and out_valid rises one edge later
// (after edge N), so c is already settled when it is first advertised.
// N must equal the package word width SM_N, which the packing helper uses.
// -----------------------------------------------------------------------------
module qmult_seq
    import qmult_seq_pkg::*;
#(
    parameter int Q = 8,
    parameter int N = SM_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int PW = 2*N - 2;
    localparam int CW = $clog2(N-1);
    localparam logic [CW-1:0] CNT_START = CW'(N-2);

    sm_state_e       state_r, state_s;
    logic [N-2:0]    ma_r, mb_r;
    logic            sgn_r;
    logic [PW-1:0]   acc_r;
    logic [CW-1:0]   cnt_r;

    logic            in_ready_r, out_valid_r, ovf_r;
    logic [N-1:0]    c_r;

    logic            accept_s, done_hs_s, calc_last_s;
    logic [CW-1:0]   shamt_s;
    logic [PW-1:0]   addend_s, acc_sum_s;
    logic            ovf_s;
    logic [N-2:0]    mag_s;

    assign accept_s    = (state_r == IDLE) & in_valid & in_ready_r;
    assign done_hs_s   = (state_r == DONE) & out_valid_r & out_ready;
    assign calc_last_s = (state_r == CALC) & (cnt_r == {CW{1'b0}});

    // Partial-product adder and result formation from the post-add accumulator.
    always_comb begin
        shamt_s   = CNT_START - cnt_r;
        addend_s  = {{(N-1){1'b0}}, ma_r} << shamt_s;
        acc_sum_s = acc_r;
        if (mb_r[0]) begin
            acc_sum_s = acc_r + addend_s;
        end else begin
            acc_sum_s = acc_r;
        end
        ovf_s = |acc_sum_s[PW-1:N-1+Q];
        mag_s = acc_sum_s[N-2+Q:Q];
        if (ovf_s) begin
            mag_s = SM_MAG_MAX;
        end else begin
            mag_s = acc_sum_s[N-2+Q:Q];
        end
    end

    // Next-state logic for the IDLE/CALC/DONE sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (done_hs_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latches, accumulator and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_r  <= {(N-1){1'b0}};
            mb_r  <= {(N-1){1'b0}};
            sgn_r <= 1'b0;
            acc_r <= {PW{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            ma_r  <= a[N-2:0];
            mb_r  <= b[N-2:0];
            sgn_r <= a[N-1] ^ b[N-1];
            acc_r <= {PW{1'b0}};
            cnt_r <= CNT_START;
        end else if (state_r == CALC) begin
            acc_r <= acc_sum_s;
            mb_r  <= mb_r >> 1;
            if (cnt_r != {CW{1'b0}}) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    // Registered handshake flags and result word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            c_r         <= {N{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_r == DONE) & ~done_hs_s;
            if (calc_last_s) begin
                c_r   <= to_sm(sgn_r, mag_s);
                ovf_r <= ovf_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_qmult_seq.sv
// -----------------------------------------------------------------------------
// tb_qmult_seq
// Directed self-checking bench for qmult_seq with Q=8, N=16. Expected values
// are hand-computed sign-magnitude products.
// -----------------------------------------------------------------------------
module tb_qmult_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c;
    logic        ovf;

    int checks;
    int errors;
    int lat;
    int seen;

    qmult_seq #(.Q(8), .N(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for in_ready, present a pair, return just after the accept edge.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL start_timeout observed=0 expected=1");
        end
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
    endtask

    // Count edges from the accept edge until out_valid is seen.
    task automatic wait_result(output int edges);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $error("FAIL result_timeout observed=0 expected=1");
        end
    endtask

    // Complete the output handshake on the next edge.
    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h0100;
        b         = 16'h0100;
        out_ready = 1'b0;

        // Reset state (inputs active but ignored)
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_c", {16'd0, c}, 32'h0000);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b0;

        // 1) 1.5 * 2.0 = 3.0, latency 16 edges
        start_op(16'h0180, 16'h0200);
        check("t1_busy_in_ready", {31'd0, in_ready}, 32'd0);
        wait_result(lat);
        check("t1_latency", lat, 32'd16);
        check("t1_c", {16'd0, c}, 32'h0300);
        check("t1_ovf", {31'd0, ovf}, 32'd0);
        finish_op();

        // 2) negative operand, and truncation to zero with no negative zero
        start_op(16'h8180, 16'h0200);
        wait_result(lat);
        check("t2_neg_c", {16'd0, c}, 32'h8300);
        finish_op();
        start_op(16'h8001, 16'h0001);
        wait_result(lat);
        check("t2_zero_c", {16'd0, c}, 32'h0000);
        check("t2_zero_ovf", {31'd0, ovf}, 32'd0);
        finish_op();

        // 3) saturation, positive and negative
        start_op(16'h7FFF, 16'h7FFF);
        wait_result(lat);
        check("t3_pos_c", {16'd0, c}, 32'h7FFF);
        check("t3_pos_ovf", {31'd0, ovf}, 32'd1);
        finish_op();
        start_op(16'hFFFF, 16'h7FFF);
        wait_result(lat);
        check("t3_neg_c", {16'd0, c}, 32'hFFFF);
        check("t3_neg_ovf", {31'd0, ovf}, 32'd1);
        finish_op();

        // 4) backpressure: 2.5 * -2.0 = -5.0 held for 5 cycles
        start_op(16'h0280, 16'h8200);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t4_hold_c", {16'd0, c}, 32'h8500);
            check("t4_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        finish_op();
        @(negedge clk);
        check("t4_rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("t4_rel_out_valid", {31'd0, out_valid}, 32'd0);

        // 5) pending pair held during busy, accepted in first IDLE cycle
        start_op(16'h0200, 16'h0100);
        in_valid = 1'b1;
        a = 16'h0100;
        b = 16'h8080;
        wait_result(lat);
        check("t5_first_c", {16'd0, c}, 32'h0200);
        check("t5_busy_in_ready", {31'd0, in_ready}, 32'd0);
        finish_op();
        @(negedge clk);
        check("t5_idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'h1234;
        b = 16'h5678;
        check("t5_accepted", {31'd0, in_ready}, 32'd0);
        wait_result(lat);
        check("t5_latency", lat, 32'd16);
        check("t5_c", {16'd0, c}, 32'h8080);
        finish_op();

        // 6) reset during CALC drops the operation
        start_op(16'h0180, 16'h0200);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
        end
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_c", {16'd0, c}, 32'h0000);
        check("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("t6_no_stale", seen, 32'd0);
        start_op(16'h0200, 16'h0200);
        wait_result(lat);
        check("t6_latency", lat, 32'd16);
        check("t6_c", {16'd0, c}, 32'h0400);
        check("t6_ovf", {31'd0, ovf}, 32'd0);
        finish_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
